cd40147_arbiter: RTL and testbench

//  Clocked 10-requester arbiter built around CD40147-style 10-to-4 priority encoding.
//  - Shares one downstream resource (bus, UART TX, display digit) between requesters req[9:0].
//  - Issues a registered one-hot grant plus its BCD index.
//  - Holds the grant until the owner releases, signals done, or hits a hold timeout.
//  - Arbitration mode: fixed priority (index 9 highest, as on the CD40147) or round-robin.

---
 rtl/cd40147_arbiter_pkg.sv | 41 ++++
 rtl/cd40147_arbiter_prio_enc10.sv | 46 ++++
 rtl/cd40147_arbiter.sv | 123 ++++++++++++
 tb/tb_cd40147_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cd40147_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cd40147_arbiter_pkg                                          |
// | Description : Shared constants, state encoding and index helpers for the   |
// |               CD40147-style 10-requester arbiter.                          |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package cd40147_arbiter_pkg;

  localparam int          N_REQ        = 10;
  localparam logic [3:0]  NO_GRANT_BCD = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // Modulo-10 addition of two BCD digits (both operands 0..9).
  function automatic logic [3:0] mod10_add(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 5'd10) begin
      s = s - 5'd10;
    end
    return s[3:0];
  endfunction

  function automatic logic [N_REQ-1:0] bcd_to_onehot(input logic [3:0] bcd);
    logic [N_REQ-1:0] v;
    v = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (bcd == 4'(i)) begin
        v[i] = 1'b1;
      end
    end
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cd40147_arbiter_prio_enc10.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cd40147_arbiter_prio_enc10                                   |
// | Description : Combinational 10-to-4 highest-index encoder (prio_enc10),    |
// |               with optional rotation for rotating-priority search.         |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module cd40147_arbiter_prio_enc10
  import cd40147_arbiter_pkg::*;
#(
  parameter bit RR = 1'b0
) (
  input  logic [N_REQ-1:0] req,
  input  logic [3:0]       rr_ptr,
  output logic [3:0]       idx,
  output logic             valid
);

  logic [3:0]       w_shift;
  logic [N_REQ-1:0] w_rot;
  logic [3:0]       w_enc;

  assign w_shift = RR ? rr_ptr : 4'd0;

  // Rotating right by rr_ptr puts requester rr_ptr-1 at the top priority slot.
  always_comb begin
    w_rot = '0;
    for (int j = 0; j < N_REQ; j++) begin
      w_rot[j] = req[mod10_add(4'(j), w_shift)];
    end
  end

  always_comb begin
    w_enc = 4'd0;
    for (int j = 0; j < N_REQ; j++) begin
      if (w_rot[j]) begin
        w_enc = 4'(j);
      end
    end
  end

  assign valid = |w_rot;
  assign idx   = mod10_add(w_enc, w_shift);

endmodule
`default_nettype wire

// File: rtl/cd40147_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cd40147_arbiter                                              |
// | Description : Clocked 10-requester arbiter, fixed or rotating priority,    |
// |               registered one-hot + BCD grant with hold timeout.            |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module cd40147_arbiter
  import cd40147_arbiter_pkg::*;
#(
  parameter bit RR       = 1'b0,
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [3:0]       gnt_bcd,
  output logic             busy,
  output logic             preempt
);

  localparam int             HC_W      = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HC_W-1:0] HOLD_LAST = (MAX_HOLD < 1) ? '0 : HC_W'(MAX_HOLD - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [N_REQ-1:0] r_gnt;
  logic [N_REQ-1:0] w_gnt_nxt;
  logic [3:0]       r_gnt_bcd;
  logic [3:0]       w_gnt_bcd_nxt;
  logic             r_preempt;
  logic             w_preempt_nxt;
  logic [3:0]       r_rr_ptr;
  logic [3:0]       w_rr_ptr_nxt;
  logic [HC_W-1:0]  r_hold_cnt;
  logic [HC_W-1:0]  w_hold_cnt_nxt;

  logic [3:0]       w_win;
  logic             w_win_vld;
  logic             w_rel_owner;
  logic             w_rel_done;
  logic             w_rel_timeout;

  cd40147_arbiter_prio_enc10 #(
    .RR (RR)
  ) u_prio_enc10 (
    .req    (req),
    .rr_ptr (r_rr_ptr),
    .idx    (w_win),
    .valid  (w_win_vld)
  );

  assign w_rel_owner   = ~|(req & r_gnt);
  assign w_rel_done    = done;
  assign w_rel_timeout = (MAX_HOLD != 0) && (r_hold_cnt == HOLD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_gnt      <= '0;
      r_gnt_bcd  <= NO_GRANT_BCD;
      r_preempt  <= 1'b0;
      r_rr_ptr   <= 4'd0;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_gnt      <= w_gnt_nxt;
      r_gnt_bcd  <= w_gnt_bcd_nxt;
      r_preempt  <= w_preempt_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_gnt_nxt      = r_gnt;
    w_gnt_bcd_nxt  = r_gnt_bcd;
    w_preempt_nxt  = 1'b0;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_hold_cnt_nxt = r_hold_cnt;
    case (r_state)
      ST_IDLE: begin
        if (en && w_win_vld) begin
          w_state_nxt    = ST_GRANT;
          w_gnt_nxt      = bcd_to_onehot(w_win);
          w_gnt_bcd_nxt  = w_win;
          w_rr_ptr_nxt   = w_win;
          w_hold_cnt_nxt = '0;
        end
      end
      ST_GRANT: begin
        // A timeout only counts as a preemption when the owner had not let go anyway.
        if (w_rel_owner || w_rel_done || w_rel_timeout) begin
          w_state_nxt   = ST_GAP;
          w_gnt_nxt     = '0;
          w_gnt_bcd_nxt = NO_GRANT_BCD;
          w_preempt_nxt = w_rel_timeout && !w_rel_owner && !w_rel_done;
        end else begin
          w_hold_cnt_nxt = r_hold_cnt + HC_W'(1);
        end
      end
      ST_GAP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt   = ST_IDLE;
        w_gnt_nxt     = '0;
        w_gnt_bcd_nxt = NO_GRANT_BCD;
      end
    endcase
  end

  assign gnt     = r_gnt;
  assign gnt_bcd = r_gnt_bcd;
  assign busy    = (r_state == ST_GRANT);
  assign preempt = r_preempt;

endmodule
`default_nettype wire

// File: tb/tb_cd40147_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_cd40147_arbiter                                           |
// | Description : Self-checking bench: fixed (MAX_HOLD=4) and round-robin      |
// |               (MAX_HOLD=16) arbiters against a behavioural model.          |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_cd40147_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [9:0] req;
  logic       done_f, done_r;
  logic [9:0] gnt_f, gnt_r;
  logic [3:0] bcd_f, bcd_r;
  logic       busy_f, busy_r, pre_f, pre_r;

  int n_checks = 0;
  int n_fail   = 0;
  bit run_chk  = 1'b0;

  always #5 clk = ~clk;

  cd40147_arbiter #(.RR(1'b0), .MAX_HOLD(4)) u_fix (
    .clk (clk), .rst (rst), .en (en), .req (req), .done (done_f),
    .gnt (gnt_f), .gnt_bcd (bcd_f), .busy (busy_f), .preempt (pre_f)
  );

  cd40147_arbiter #(.RR(1'b1), .MAX_HOLD(16)) u_rr (
    .clk (clk), .rst (rst), .en (en), .req (req), .done (done_r),
    .gnt (gnt_r), .gnt_bcd (bcd_r), .busy (busy_r), .preempt (pre_r)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model: unit 0 = fixed priority, unit 1 = round-robin.
  int m_owner[2];
  int m_hold[2];
  int m_blank[2];
  int m_last[2];
  bit m_pre[2];
  int mh_of[2] = '{4, 16};
  bit rr_of[2] = '{1'b0, 1'b1};

  function automatic int pick(input bit rr, input int last, input logic [9:0] r);
    if (!rr) begin
      for (int i = 9; i >= 0; i--) if (r[i]) return i;
    end else begin
      for (int k = 1; k <= 10; k++) begin
        int idx;
        idx = (last - k + 20) % 10;
        if (r[idx]) return idx;
      end
    end
    return -1;
  endfunction

  function automatic logic [9:0] exp_gnt(input int o);
    logic [9:0] one;
    one = 10'd1;
    return (o < 0) ? 10'd0 : (one << o);
  endfunction

  function automatic logic [3:0] exp_bcd(input int o);
    return (o < 0) ? 4'hF : 4'(o);
  endfunction

  always @(posedge clk or posedge rst) begin : model_upd
    bit a, b, c;
    bit dn[2];
    dn[0] = done_f;
    dn[1] = done_r;
    for (int u = 0; u < 2; u++) begin
      if (rst) begin
        m_owner[u] = -1; m_hold[u] = 0; m_blank[u] = 0; m_last[u] = 0; m_pre[u] = 1'b0;
      end else begin
        m_pre[u] = 1'b0;
        if (m_owner[u] >= 0) begin
          a = !req[m_owner[u]];
          b = dn[u];
          c = (mh_of[u] != 0) && (m_hold[u] == mh_of[u] - 1);
          if (a || b || c) begin
            m_pre[u]   = c && !a && !b;
            m_owner[u] = -1;
            m_blank[u] = 1;
          end else begin
            m_hold[u]++;
          end
        end else if (m_blank[u] > 0) begin
          m_blank[u]--;
        end else if (en && (req != 10'd0)) begin
          m_owner[u] = pick(rr_of[u], m_last[u], req);
          m_last[u]  = m_owner[u];
          m_hold[u]  = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (run_chk) begin
      chk("gnt_f",  32'(gnt_f),  32'(exp_gnt(m_owner[0])));
      chk("bcd_f",  32'(bcd_f),  32'(exp_bcd(m_owner[0])));
      chk("busy_f", 32'(busy_f), 32'(m_owner[0] >= 0));
      chk("pre_f",  32'(pre_f),  32'(m_pre[0]));
      chk("gnt_r",  32'(gnt_r),  32'(exp_gnt(m_owner[1])));
      chk("bcd_r",  32'(bcd_r),  32'(exp_bcd(m_owner[1])));
      chk("busy_r", 32'(busy_r), 32'(m_owner[1] >= 0));
      chk("pre_r",  32'(pre_r),  32'(m_pre[1]));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_rr_busy(input int lim);
    for (int i = 0; i < lim && !busy_r; i++) tick();
    if (!busy_r) chk("rr_wait_timeout", 32'(busy_r), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; req = 10'h3FF; done_f = 1'b0; done_r = 1'b0;
    repeat (2) tick();
    chk("rst_gnt_f",  32'(gnt_f),  32'd0);
    chk("rst_bcd_f",  32'(bcd_f),  32'hF);
    chk("rst_busy_r", 32'(busy_r), 32'd0);
    chk("rst_bcd_r",  32'(bcd_r),  32'hF);
    rst = 1'b0;
    tick();
    chk("post_rst_gnt_f", 32'(gnt_f), 32'd0);
    chk("post_rst_bcd_r", 32'(bcd_r), 32'hF);
    run_chk = 1'b1;

    // Fixed priority: 9 beats 0, then 0 after release.
    en = 1'b1; req = 10'b1000000001;
    tick();
    chk("fix_first_bcd", 32'(bcd_f), 32'd9);
    chk("fix_first_gnt", 32'(gnt_f), 32'h200);
    chk("rr_first_bcd",  32'(bcd_r), 32'd9);
    req = 10'h001;
    tick();
    chk("fix_gap", 32'(gnt_f), 32'd0);
    repeat (2) tick();
    chk("fix_next_bcd", 32'(bcd_f), 32'd0);

    // Timeout on the MAX_HOLD=4 unit.
    req = 10'h000; repeat (4) tick();
    req = 10'h008;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("to_hold_bcd", 32'(bcd_f), 32'd3);
    end
    tick();
    chk("to_rel_bcd", 32'(bcd_f), 32'hF);
    chk("to_preempt", 32'(pre_f), 32'd1);
    tick();
    chk("to_preempt_clr", 32'(pre_f), 32'd0);
    tick();
    chk("to_regrant", 32'(bcd_f), 32'd3);

    // done coincident with timeout: plain release.
    req = 10'h000; repeat (4) tick();
    req = 10'h008; repeat (4) tick();
    done_f = 1'b1;
    tick();
    done_f = 1'b0;
    chk("dt_preempt", 32'(pre_f), 32'd0);
    chk("dt_rel_gnt", 32'(gnt_f), 32'd0);

    // en gating.
    req = 10'h000; repeat (4) tick();
    en = 1'b0; req = 10'h010;
    repeat (3) begin
      tick();
      chk("en_low_f", 32'(gnt_f), 32'd0);
      chk("en_low_r", 32'(gnt_r), 32'd0);
    end
    en = 1'b1;
    tick();
    chk("en_hi_f", 32'(bcd_f), 32'd4);
    chk("en_hi_r", 32'(bcd_r), 32'd4);
    en = 1'b0;
    tick();
    chk("en_low_keep_r", 32'(bcd_r), 32'd4);
    en = 1'b1;

    // Round-robin rotation from a fresh reset.
    req = 10'h000; repeat (3) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    req = 10'h3FF;
    for (int k = 0; k <= 10; k++) begin
      wait_rr_busy(8);
      chk("rr_seq", 32'(bcd_r), 32'((19 - k) % 10));
      done_r = 1'b1;
      tick();
      done_r = 1'b0;
    end

    // Async reset mid-grant.
    req = 10'h020;
    wait_rr_busy(8);
    chk("rr_owner5", 32'(bcd_r), 32'd5);
    #3 rst = 1'b1;
    #1;
    chk("async_gnt_r",  32'(gnt_r),  32'd0);
    chk("async_bcd_r",  32'(bcd_r),  32'hF);
    chk("async_busy_r", 32'(busy_r), 32'd0);
    chk("async_gnt_f",  32'(gnt_f),  32'd0);
    tick();
    rst = 1'b0; req = 10'h201;
    tick();
    chk("post_async_r", 32'(bcd_r), 32'd9);
    chk("post_async_f", 32'(bcd_f), 32'd9);

    // Randomized traffic against the model.
    repeat (600) begin
      case ($urandom_range(0, 3))
        0:       req = 10'h000;
        1:       req = 10'd1 << $urandom_range(0, 9);
        default: req = 10'($urandom & 32'h3FF);
      endcase
      en     = ($urandom_range(0, 9) != 0);
      done_f = ($urandom_range(0, 5) == 0);
      done_r = ($urandom_range(0, 5) == 0);
      tick();
    end
    done_f = 1'b0; done_r = 1'b0; req = 10'h000;
    tick();
    run_chk = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
